// File: rtl/io_port_pkg.sv
// Shared definitions for the GPIO port bank: register encodings and pin-vector helpers.
package io_port_pkg;

    localparam int REG_SEL_SIZE      = 2;
    localparam int DEFAULT_DATA_SIZE = 8;

    typedef enum logic [REG_SEL_SIZE-1:0] {
        REG_DATA = 2'd0,
        REG_DIR  = 2'd1,
        REG_MASK = 2'd2,
        REG_PEND = 2'd3
    } reg_sel_e;

    // Base bit index of port p inside the flattened pin vectors.
    function automatic int port_slice(input int p, input int width = DEFAULT_DATA_SIZE);
        return p * width;
    endfunction

endpackage

// File: rtl/io_port_bank_if.sv
// Register-select/strobe bus between the MCU controller (master) and the port bank (slave).
interface io_port_bank_if
    import io_port_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int SEL_SIZE  = 2
) ();

    logic                    wr_en;
    logic                    rd_en;
    logic [SEL_SIZE-1:0]     port_sel;
    logic [REG_SEL_SIZE-1:0] reg_sel;
    logic [DATA_SIZE-1:0]    wr_data;
    logic [DATA_SIZE-1:0]    rd_data;
    logic                    rd_valid;

    modport master (
        output wr_en, rd_en, port_sel, reg_sel, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, rd_en, port_sel, reg_sel, wr_data,
        output rd_data, rd_valid
    );

endinterface

// File: rtl/io_port_channel.sv
// One GPIO port: DATA/DIR/MASK/PEND registers, input synchroniser, rising-edge
// capture into sticky pending flags, read mux and a local interrupt.
module io_port_channel
    import io_port_pkg::*;
#(
    parameter int DATA_SIZE   = DEFAULT_DATA_SIZE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  reg_sel_e             reg_sel,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic [DATA_SIZE-1:0] pin_in,
    output logic [DATA_SIZE-1:0] pin_out,
    output logic [DATA_SIZE-1:0] pin_oe,
    output logic [DATA_SIZE-1:0] rd_val,
    output logic                 irq
);

    logic [DATA_SIZE-1:0] data_q;
    logic [DATA_SIZE-1:0] dir_q;
    logic [DATA_SIZE-1:0] mask_q;
    logic [DATA_SIZE-1:0] pend_q;
    logic [DATA_SIZE-1:0] sync_q [SYNC_STAGES];
    logic [DATA_SIZE-1:0] p_in;
    logic [DATA_SIZE-1:0] s_in;
    logic [DATA_SIZE-1:0] edge_set;
    logic [DATA_SIZE-1:0] pend_clr;

    assign s_in = sync_q[SYNC_STAGES-1];

    // p_in follows s_in unconditionally, so DIR/MASK changes can never expose a stale edge.
    assign edge_set = s_in & ~p_in & ~dir_q & mask_q;
    assign pend_clr = (wr_en && reg_sel == REG_PEND) ? wr_data : '0;

    // Pad synchroniser chain and previous-value flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            p_in <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            p_in <= s_in;
        end
    end

    // DATA/DIR/MASK register writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            dir_q  <= '0;
            mask_q <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                REG_DATA: data_q <= wr_data;
                REG_DIR:  dir_q  <= wr_data;
                REG_MASK: mask_q <= wr_data;
                default:  ;
            endcase
        end
    end

    // Sticky pending flags; a new edge beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= '0;
        else     pend_q <= (pend_q & ~pend_clr) | edge_set;
    end

    // Register read mux; DATA shows the latch on driven bits and the pad elsewhere.
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_DATA: rd_val = (dir_q & data_q) | (~dir_q & s_in);
            REG_DIR:  rd_val = dir_q;
            REG_MASK: rd_val = mask_q;
            REG_PEND: rd_val = pend_q;
            default:  rd_val = '0;
        endcase
    end

    assign pin_out = data_q;
    assign pin_oe  = dir_q;
    assign irq     = |(pend_q & mask_q);

endmodule

// File: rtl/io_port_bank.sv
// Bank of NUM_PORTS GPIO channels: address decode, registered read path and combined irq.
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int DATA_SIZE   = DEFAULT_DATA_SIZE,
    parameter int NUM_PORTS   = 4,
    parameter int SEL_SIZE    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    io_port_bank_if.slave                  bus,
    input  logic [NUM_PORTS*DATA_SIZE-1:0] pin_in,
    output logic [NUM_PORTS*DATA_SIZE-1:0] pin_out,
    output logic [NUM_PORTS*DATA_SIZE-1:0] pin_oe,
    output logic                           irq
);

    logic [NUM_PORTS-1:0][DATA_SIZE-1:0] ch_rd;
    logic [NUM_PORTS-1:0]                ch_irq;
    logic [NUM_PORTS-1:0]                wr_hit;
    logic [DATA_SIZE-1:0]                rd_mux;
    logic [DATA_SIZE-1:0]                rd_data_q;
    logic                                rd_valid_q;
    reg_sel_e                            reg_sel;

    assign reg_sel = reg_sel_e'(bus.reg_sel);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        // Writes to port indices beyond NUM_PORTS match no channel and are dropped.
        assign wr_hit[p] = bus.wr_en && (bus.port_sel == SEL_SIZE'(p));

        io_port_channel #(
            .DATA_SIZE   (DATA_SIZE),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_channel (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_hit[p]),
            .reg_sel (reg_sel),
            .wr_data (bus.wr_data),
            .pin_in  (pin_in [port_slice(p, DATA_SIZE) +: DATA_SIZE]),
            .pin_out (pin_out[port_slice(p, DATA_SIZE) +: DATA_SIZE]),
            .pin_oe  (pin_oe [port_slice(p, DATA_SIZE) +: DATA_SIZE]),
            .rd_val  (ch_rd[p]),
            .irq     (ch_irq[p])
        );
    end

    // Select the addressed channel's read value; unimplemented ports read as zero.
    always_comb begin
        rd_mux = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.port_sel == SEL_SIZE'(p)) rd_mux = ch_rd[p];
        end
    end

    // Registered read response; sampling pre-edge register state gives read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= rd_mux;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign irq          = |ch_irq;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank with three 8-bit ports and a two-stage synchroniser.
module tb_io_port_bank;
    import io_port_pkg::*;

    localparam int DW = 8;
    localparam int NP = 3;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP*DW-1:0]  pin_in = '0;
    logic [NP*DW-1:0]  pin_out;
    logic [NP*DW-1:0]  pin_oe;
    logic              irq;

    int checks   = 0;
    int failures = 0;

    io_port_bank_if #(.DATA_SIZE(DW), .SEL_SIZE(SW)) bus ();

    io_port_bank #(
        .DATA_SIZE   (DW),
        .NUM_PORTS   (NP),
        .SEL_SIZE    (SW),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input int port, input reg_sel_e rs, input logic [DW-1:0] d);
        bus.wr_en    = 1'b1;
        bus.port_sel = SW'(port);
        bus.reg_sel  = rs;
        bus.wr_data  = d;
        tick();
        bus.wr_en    = 1'b0;
    endtask

    task automatic do_read(input int port, input reg_sel_e rs,
                           output logic [DW-1:0] d, output logic v);
        bus.rd_en    = 1'b1;
        bus.port_sel = SW'(port);
        bus.reg_sel  = rs;
        tick();
        bus.rd_en    = 1'b0;
        d = bus.rd_data;
        v = bus.rd_valid;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        logic v;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick();
        do_write(0, REG_DIR, 8'hFF);
        do_write(0, REG_DATA, 8'hAA);
        do_read(0, REG_DIR, d, v);
        checks++;
        if (pin_out[7:0] !== 8'hAA || d !== 8'hFF) begin
            failures++;
            $display("FAIL reset_pre: pin_out=%h rd=%h expected AA/FF", pin_out[7:0], d);
        end
        // reset lands in the middle of a write and a read
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.port_sel = 0;
        bus.reg_sel = REG_DATA; bus.wr_data = 8'h55;
        rst = 1'b1;
        tick();
        checks++;
        if (pin_out !== '0 || pin_oe !== '0 || bus.rd_data !== '0 || bus.rd_valid !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: out=%h oe=%h rd=%h v=%b irq=%b expected all 0",
                     pin_out, pin_oe, bus.rd_data, bus.rd_valid, irq);
        end
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        pin_in = 24'h00_00_3C;
        rst = 1'b0;
        tick(3);
        do_read(0, REG_DATA, d, v);
        checks++;
        if (d !== 8'h3C || v !== 1'b1) begin
            failures++;
            $display("FAIL reset_sync_read: rd=%h v=%b expected 3C/1", d, v);
        end
    endtask

    task automatic test_dir_data();
        logic [DW-1:0] d;
        logic v;
        do_write(1, REG_DIR, 8'hF0);
        do_write(1, REG_DATA, 8'hA5);
        checks++;
        if (pin_oe !== 24'h00_F0_00 || pin_out !== 24'h00_A5_00) begin
            failures++;
            $display("FAIL dir_data_pins: oe=%h out=%h expected 00F000/00A500", pin_oe, pin_out);
        end
        pin_in[15:8] = 8'h0F;
        tick(3);
        do_read(1, REG_DATA, d, v);
        checks++;
        if (d !== 8'hAF || v !== 1'b1) begin
            failures++;
            $display("FAIL dir_data_mixed_read: rd=%h v=%b expected AF/1", d, v);
        end
        tick();
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'hAF) begin
            failures++;
            $display("FAIL rd_hold: v=%b rd=%h expected 0/AF", bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_edge_irq();
        logic [DW-1:0] d;
        logic v;
        do_write(0, REG_MASK, 8'h01);
        tick();
        pin_in[0] = 1'b1;
        tick(2);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL edge_early: irq=%b after 2 edges expected 0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL edge_latency: irq=%b after 3 edges expected 1", irq);
        end
        do_read(0, REG_PEND, d, v);
        checks++;
        if (d !== 8'h01) begin
            failures++;
            $display("FAIL edge_pend: rd=%h expected 01", d);
        end
        do_write(0, REG_MASK, 8'h00);
        do_read(0, REG_PEND, d, v);
        checks++;
        if (irq !== 1'b0 || d !== 8'h01) begin
            failures++;
            $display("FAIL mask_clear: irq=%b pend=%h expected 0/01", irq, d);
        end
        do_write(0, REG_MASK, 8'h01);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL mask_restore: irq=%b expected 1", irq);
        end
        do_write(0, REG_PEND, 8'h01);
        do_read(0, REG_PEND, d, v);
        checks++;
        if (irq !== 1'b0 || d !== 8'h00) begin
            failures++;
            $display("FAIL w1c: irq=%b pend=%h expected 0/00", irq, d);
        end
    endtask

    task automatic test_no_spurious();
        logic [DW-1:0] d;
        logic v;
        // pin_in[0] is high and MASK[0] bit0 set; rewriting MASK must not invent an edge
        do_write(0, REG_MASK, 8'h00);
        do_write(0, REG_MASK, 8'h01);
        tick(4);
        do_read(0, REG_PEND, d, v);
        checks++;
        if (d !== 8'h00 || irq !== 1'b0) begin
            failures++;
            $display("FAIL mask_no_edge: pend=%h irq=%b expected 00/0", d, irq);
        end
        // output-mode bit sees a real pad rise but must not capture it
        do_write(0, REG_DIR, 8'h01);
        pin_in[0] = 1'b0;
        tick(4);
        pin_in[0] = 1'b1;
        tick(4);
        do_read(0, REG_PEND, d, v);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL output_no_pend: pend=%h expected 00", d);
        end
        do_write(0, REG_DIR, 8'h00);
        tick(4);
        do_read(0, REG_PEND, d, v);
        checks++;
        if (d !== 8'h00 || irq !== 1'b0) begin
            failures++;
            $display("FAIL dir_no_edge: pend=%h irq=%b expected 00/0", d, irq);
        end
    endtask

    task automatic test_w1c_race();
        logic [DW-1:0] d;
        logic v;
        pin_in[0] = 1'b0;
        tick(4);
        pin_in[0] = 1'b1;
        tick(2);
        // the clear is sampled on the same edge that sets PEND bit 0
        do_write(0, REG_PEND, 8'h01);
        do_read(0, REG_PEND, d, v);
        checks++;
        if (d !== 8'h01 || irq !== 1'b1) begin
            failures++;
            $display("FAIL w1c_race: pend=%h irq=%b expected 01/1", d, irq);
        end
        do_write(0, REG_PEND, 8'h01);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL w1c_after_race: irq=%b expected 0", irq);
        end
    endtask

    task automatic test_bad_port();
        logic [DW-1:0] d;
        logic v;
        do_write(3, REG_DATA, 8'hFF);
        do_write(3, REG_DIR, 8'hFF);
        do_write(3, REG_MASK, 8'hFF);
        do_write(3, REG_PEND, 8'hFF);
        checks++;
        if (pin_out !== 24'h00_A5_00 || pin_oe !== 24'h00_F0_00 || irq !== 1'b0) begin
            failures++;
            $display("FAIL bad_port_write: out=%h oe=%h irq=%b expected 00A500/00F000/0",
                     pin_out, pin_oe, irq);
        end
        do_read(2, REG_MASK, d, v);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL bad_port_alias: mask2=%h expected 00", d);
        end
        do_read(1, REG_DIR, d, v);
        do_read(3, REG_DATA, d, v);
        checks++;
        if (d !== 8'h00 || v !== 1'b1) begin
            failures++;
            $display("FAIL bad_port_read: rd=%h v=%b expected 00/1", d, v);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic v;
        do_write(2, REG_DIR, 8'hFF);
        do_write(2, REG_DATA, 8'h11);
        bus.rd_en = 1'b1;
        do_write(2, REG_DATA, 8'h22);
        bus.rd_en = 1'b0;
        checks++;
        if (bus.rd_data !== 8'h11 || bus.rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL wr_rd_same_cycle: rd=%h v=%b expected 11/1", bus.rd_data, bus.rd_valid);
        end
        checks++;
        if (pin_out[23:16] !== 8'h22) begin
            failures++;
            $display("FAIL wr_rd_write: out=%h expected 22", pin_out[23:16]);
        end
        do_read(2, REG_DATA, d, v);
        checks++;
        if (d !== 8'h22) begin
            failures++;
            $display("FAIL wr_rd_followup: rd=%h expected 22", d);
        end
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.rd_en    = 1'b0;
        bus.port_sel = '0;
        bus.reg_sel  = '0;
        bus.wr_data  = '0;
        test_reset();
        test_dir_data();
        test_edge_irq();
        test_no_spurious();
        test_w1c_race();
        test_bad_port();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
